// File: rtl/disp_bin2bcd_if.sv
// Request/result bundle between a binary-value producer and the
// binary-to-BCD converter that feeds the seven-segment multiplexer.
interface disp_bin2bcd_if #(
   parameter int W = 14
);
   logic         start;
   logic [W-1:0] bin;
   logic         blank_lz;
   logic         ready;
   logic         done;
   logic         overflow;
   logic [3:0]   hex3;
   logic [3:0]   hex2;
   logic [3:0]   hex1;
   logic [3:0]   hex0;

   modport master (
      output start, bin, blank_lz,
      input  ready, done, overflow, hex3, hex2, hex1, hex0
   );

   modport slave (
      input  start, bin, blank_lz,
      output ready, done, overflow, hex3, hex2, hex1, hex0
   );
endinterface

// File: rtl/disp_bin2bcd.sv
// Sequential double-dabble converter: W-bit binary to four display digit codes,
// one bit per clock, with optional leading-zero blanking and overflow glyphs.
module disp_bin2bcd #(
   parameter int W = 14
) (
   input logic          clk,
   input logic          rst,
   disp_bin2bcd_if.slave bus
);
   localparam int SW = 16 + W;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t        state_reg;
   state_t        state_next;
   logic [SW-1:0] sr_reg;
   logic [3:0]    cnt_reg;
   logic          blank_reg;
   logic          ovf_cap_reg;
   logic          done_reg;
   logic          overflow_reg;
   logic [3:0]    hex_reg [4];

   logic [3:0]    digit [4];
   logic [15:0]   adj;
   logic [3:0]    code [4];
   logic          lead3;
   logic          lead2;
   logic          lead1;
   logic          bin_ovf;

   // BCD nibbles sit above the binary field; each is pre-corrected before the shift.
   for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      assign digit[gi]        = sr_reg[W + 4*gi +: 4];
      assign adj[4*gi +: 4]   = (digit[gi] >= 4'd5) ? digit[gi] + 4'd3 : digit[gi];
   end

   assign bin_ovf = 32'(bus.bin) > 32'd9999;

   always_comb begin
      lead3 = (digit[3] == 4'd0);
      lead2 = lead3 && (digit[2] == 4'd0);
      lead1 = lead2 && (digit[1] == 4'd0);
      code[3] = digit[3];
      code[2] = digit[2];
      code[1] = digit[1];
      code[0] = digit[0];
      if (ovf_cap_reg) begin
         code[3] = 4'hf;
         code[2] = 4'hf;
         code[1] = 4'hf;
         code[0] = 4'hf;
      end else if (blank_reg) begin
         // Units digit always stays visible so zero still shows as "0".
         if (lead3) code[3] = 4'hc;
         if (lead2) code[2] = 4'hc;
         if (lead1) code[1] = 4'hc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (bus.start) state_next = CONV;
         CONV: if (cnt_reg == 4'(W - 1)) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_reg       <= '0;
         cnt_reg      <= '0;
         blank_reg    <= 1'b0;
         ovf_cap_reg  <= 1'b0;
         done_reg     <= 1'b0;
         overflow_reg <= 1'b0;
         for (int i = 0; i < 4; i++) hex_reg[i] <= 4'hc;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  sr_reg      <= {16'd0, bus.bin};
                  cnt_reg     <= '0;
                  blank_reg   <= bus.blank_lz;
                  ovf_cap_reg <= bin_ovf;
               end
            end
            CONV: begin
               sr_reg  <= {adj, sr_reg[W-1:0]} << 1;
               cnt_reg <= cnt_reg + 4'd1;
            end
            DONE: begin
               for (int i = 0; i < 4; i++) hex_reg[i] <= code[i];
               overflow_reg <= ovf_cap_reg;
               done_reg     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.ready    = (state_reg == IDLE);
   assign bus.done     = done_reg;
   assign bus.overflow = overflow_reg;
   assign bus.hex3     = hex_reg[3];
   assign bus.hex2     = hex_reg[2];
   assign bus.hex1     = hex_reg[1];
   assign bus.hex0     = hex_reg[0];
endmodule

// File: tb/tb_disp_bin2bcd.sv
// Bench for disp_bin2bcd: a cycle-level arithmetic model checked every cycle,
// plus directed conversions with hand-computed digit expectations.
module tb_disp_bin2bcd;
   localparam int W = 14;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;

   disp_bin2bcd_if #(.W(W)) bus ();

   disp_bin2bcd #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Expected {overflow, hex3, hex2, hex1, hex0} from plain decimal arithmetic.
   function automatic logic [16:0] calc(input int v, input bit bl);
      logic [3:0] d [4];
      if (v > 9999) return {1'b1, 16'hffff};
      d[3] = 4'(v / 1000);
      d[2] = 4'((v / 100) % 10);
      d[1] = 4'((v / 10) % 10);
      d[0] = 4'(v % 10);
      if (bl && d[3] == 4'd0) begin
         d[3] = 4'hc;
         if (d[2] == 4'd0) begin
            d[2] = 4'hc;
            if (d[1] == 4'd0) d[1] = 4'hc;
         end
      end
      return {1'b0, d[3], d[2], d[1], d[0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: busy for W+1 edges after acceptance, results appear on the last.
   int          m_cnt  = 0;
   int          m_bin  = 0;
   bit          m_bl   = 1'b0;
   bit          m_done = 1'b0;
   logic [16:0] m_res  = {1'b0, 16'hcccc};

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt  = 0;
         m_done = 1'b0;
         m_res  = {1'b0, 16'hcccc};
      end else begin
         m_done = 1'b0;
         if (m_cnt == 0) begin
            if (bus.start === 1'b1) begin
               m_bin = int'(bus.bin);
               m_bl  = bus.blank_lz;
               m_cnt = W + 1;
            end
         end else begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_res  = calc(m_bin, m_bl);
               m_done = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", 32'(bus.ready), 32'(m_cnt == 0));
         chk("done", 32'(bus.done), 32'(m_done));
         chk("overflow", 32'(bus.overflow), 32'(m_res[16]));
         chk("hex", 32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'(m_res[15:0]));
      end
   end

   function automatic logic [16:0] dut_res();
      return {bus.overflow, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
   endfunction

   task automatic do_start(input int v, input bit bl);
      @(posedge clk); #2;
      bus.bin      = W'(v);
      bus.blank_lz = bl;
      bus.start    = 1'b1;
      @(posedge clk); #2;
      bus.start    = 1'b0;
   endtask

   // Counts negedges until done; n includes the done cycle.
   task automatic wait_done(input string name, output int n, output int low);
      bit seen = 1'b0;
      n = 0;
      low = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         n++;
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bus.ready === 1'b0) low++;
      end
      chk({name, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic conv_check(input int v, input bit bl, input logic [16:0] exp, input string name);
      int n, low;
      do_start(v, bl);
      wait_done(name, n, low);
      chk({name, "_res"}, 32'(dut_res()), 32'(exp));
      chk({name, "_latency"}, n, W + 2);
      $display("conv %s bin=%0d blank=%0b -> ovf=%0b hex=%h", name, v, bl, bus.overflow,
               {bus.hex3, bus.hex2, bus.hex1, bus.hex0});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, low, ndone;
      logic [16:0] r;
      rst          = 1'b0;
      bus.start    = 1'b0;
      bus.bin      = '0;
      bus.blank_lz = 1'b0;
      @(posedge clk); #2;
      chk_en = 1'b1;
      @(posedge clk); #2;
      chk("rst_hex", 32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'hcccc);
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      rst = 1'b1;

      // Pin the model to hand-computed digits.
      chk("model_1234", 32'(calc(1234, 1'b0)), 32'h01234);
      chk("model_0_bl", 32'(calc(0, 1'b1)), 32'h0ccc0);
      chk("model_10000", 32'(calc(10000, 1'b1)), 32'h1ffff);

      do_start(1234, 1'b0);
      wait_done("c1234", n, low);
      chk("c1234_res", 32'(dut_res()), 32'h01234);
      chk("c1234_latency", n, 16);
      chk("c1234_ready_low", low, 15);
      $display("conv c1234 bin=1234 blank=0 -> hex=%h", {bus.hex3, bus.hex2, bus.hex1, bus.hex0});
      repeat (5) @(negedge clk);
      chk("c1234_hold", 32'(dut_res()), 32'h01234);

      conv_check(42,    1'b1, 17'h0cc42, "c42_bl");
      conv_check(0,     1'b1, 17'h0ccc0, "c0_bl");
      conv_check(1004,  1'b1, 17'h01004, "c1004_bl");
      conv_check(0,     1'b0, 17'h00000, "c0");
      conv_check(9999,  1'b0, 17'h09999, "c9999");
      conv_check(10000, 1'b0, 17'h1ffff, "c10000");
      conv_check(16383, 1'b1, 17'h1ffff, "c16383_bl");

      // Start while busy is ignored.
      do_start(5678, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      bus.bin   = W'(1111);
      bus.start = 1'b1;
      @(posedge clk); #2;
      bus.start = 1'b0;
      ndone = 0;
      r = '0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ndone++;
            r = dut_res();
         end
      end
      chk("busy_start_ndone", ndone, 1);
      chk("busy_start_res", 32'(r), 32'h05678);
      $display("conv busy_start bin=5678 -> hex=%h dones=%0d", r[15:0], ndone);

      // Start held high: re-accepted on the done-cycle edge.
      @(posedge clk); #2;
      bus.bin      = W'(250);
      bus.blank_lz = 1'b0;
      bus.start    = 1'b1;
      @(posedge clk); #2;
      bus.bin = W'(77);
      wait_done("b2b_first", n, low);
      chk("b2b_first_res", 32'(dut_res()), 32'h00250);
      $display("conv b2b_first bin=250 -> hex=%h", {bus.hex3, bus.hex2, bus.hex1, bus.hex0});
      @(posedge clk); #2;
      bus.start = 1'b0;
      wait_done("b2b_second", n, low);
      chk("b2b_second_res", 32'(dut_res()), 32'h00077);
      chk("b2b_second_latency", n, 16);
      $display("conv b2b_second bin=77 -> hex=%h", {bus.hex3, bus.hex2, bus.hex1, bus.hex0});

      // Reset mid-conversion.
      do_start(3210, 1'b0);
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_hex", 32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'hcccc);
      chk("midrst_ready", 32'(bus.ready), 32'd1);
      ndone = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      @(posedge clk); #2;
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      chk("midrst_no_done", ndone, 0);
      $display("conv midrst bin=3210 aborted, dones=%0d", ndone);
      conv_check(3210, 1'b0, 17'h03210, "c3210_after_rst");

      // Randomized conversions with input noise while busy.
      for (int t = 0; t < 60; t++) begin
         int v;
         bit bl;
         v  = int'($urandom_range(0, 16383));
         bl = 1'($urandom_range(0, 1));
         do_start(v, bl);
         for (int k = 0; k < 8; k++) begin
            @(posedge clk); #2;
            bus.start    = 1'($urandom_range(0, 1));
            bus.bin      = W'($urandom_range(0, 16383));
            bus.blank_lz = 1'($urandom_range(0, 1));
         end
         bus.start = 1'b0;
         wait_done("rand", n, low);
         chk("rand_res", 32'(dut_res()), 32'(calc(v, bl)));
         $display("conv rand bin=%0d blank=%0b -> ovf=%0b hex=%h", v, bl, bus.overflow,
                  {bus.hex3, bus.hex2, bus.hex1, bus.hex0});
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
